vga_timing_gen: RTL

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz system clock.
Produces raw 10-bit draw coordinates DRAW_X and DRAW_Y, active-low syncs, a blank flag, a pixel-clock enable, and line/frame boundary pulses.
It sits directly upstream of the 2x downscale coordinate mapper, which converts DRAW_X/DRAW_Y to 320x240 space. It also feeds the frame-buffer read path and the DAC.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_pix_div.sv | 34 +++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate type and totals.
// Defaults describe 640x480 @ 60 Hz from a 50 MHz clock.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int h_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: phase counter plus a registered
// one-cycle strobe that is high while phase = CLK_DIV-1.
module vga_pix_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam logic [1:0] LAST = 2'(CLK_DIV - 1);

  logic [1:0] phase;
  logic [1:0] phase_nxt;

  always_comb begin
    phase_nxt = (phase == LAST) ? 2'd0 : phase + 2'd1;
  end

  // Strobe is registered from the next phase so it lines up
  // with phase itself reaching LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 2'd0;
      pix_en <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      pix_en <= (phase_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, X/Y counters, and
// sync/blank decode registered alongside the coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic   Clk,
  input  logic   Reset_n,
  output logic   PIX_EN,
  output coord_t DRAW_X,
  output coord_t DRAW_Y,
  output logic   HS_N,
  output logic   VS_N,
  output logic   BLANK_N,
  output logic   LINE_END,
  output logic   FRAME_END
);

  localparam int H_TOTAL =
    h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_timing_gen: line or frame total exceeds 1024");
  end

  if (CLK_DIV < 2 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 2..4");
  end

  localparam int EW = COORD_W + 1;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  localparam logic [EW-1:0] HV_LIM = EW'(H_VISIBLE);
  localparam logic [EW-1:0] VV_LIM = EW'(V_VISIBLE);
  localparam logic [EW-1:0] HS_BEG = EW'(H_VISIBLE + H_FRONT);
  localparam logic [EW-1:0] HS_END =
    EW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [EW-1:0] VS_BEG = EW'(V_VISIBLE + V_FRONT);
  localparam logic [EW-1:0] VS_END =
    EW'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t        x_nxt;
  coord_t        y_nxt;
  logic [EW-1:0] xe;
  logic [EW-1:0] ye;
  logic          hs_on;
  logic          vs_on;
  logic          vis_on;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .pix_en (PIX_EN)
  );

  always_comb begin
    x_nxt = DRAW_X;
    y_nxt = DRAW_Y;
    if (PIX_EN) begin
      if (DRAW_X == H_LAST) begin
        x_nxt = '0;
        y_nxt = (DRAW_Y == V_LAST) ? '0 : DRAW_Y + 1'b1;
      end else begin
        x_nxt = DRAW_X + 1'b1;
      end
    end
  end

  // Decode from the next coordinates so control and
  // coordinates leave the same flop stage together.
  always_comb begin
    xe     = {1'b0, x_nxt};
    ye     = {1'b0, y_nxt};
    hs_on  = (xe >= HS_BEG) && (xe < HS_END);
    vs_on  = (ye >= VS_BEG) && (ye < VS_END);
    vis_on = (xe < HV_LIM) && (ye < VV_LIM);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DRAW_X  <= '0;
      DRAW_Y  <= '0;
      HS_N    <= 1'b1;
      VS_N    <= 1'b1;
      BLANK_N <= 1'b1;
    end else begin
      DRAW_X  <= x_nxt;
      DRAW_Y  <= y_nxt;
      HS_N    <= ~hs_on;
      VS_N    <= ~vs_on;
      BLANK_N <= vis_on;
    end
  end

  assign LINE_END  = PIX_EN & (DRAW_X == H_LAST);
  assign FRAME_END = LINE_END & (DRAW_Y == V_LAST);

endmodule
